// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch and next-PC selection.
//
// Holds the PC and fetches one instruction at a time from instruction
// memory. The returned word is held in instr and decoded into op_c and
// funct for the control decoder. When the core retires the held
// instruction, the decoder's {jr, j, branch} select picks the next PC and
// the next fetch begins.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   pc_next_c[2:0]    {jr, j, branch} select, sampled on retire only
//   reg_a[31:0]       jr target, sampled on retire only
//   retire            the held instruction finished executing this cycle
//   imem_req          fetch request, held high until imem_ack
//   imem_addr[31:0]   fetch address, always equal to pc
//   imem_ack          memory returned data for the current request
//   imem_err          access failed, qualified by imem_ack
//   imem_rdata[31:0]  instruction word, valid with imem_ack
//   instr[31:0]       held instruction word
//   op_c[5:0]         instr[31:26]
//   funct[5:0]        instr[5:0]
//   instr_valid       instr/op_c/funct valid for execution
//   pc[31:0]          address of the held instruction
//   pc_plus4[31:0]    pc + 4, wrapping
//   fault             sticky fetch-error or jr-misalignment fault
//
// Handshake: imem_req is a request that stays asserted, with imem_addr
// stable, from the first FETCH cycle until the edge at which imem_ack is
// sampled high; a transfer completes on exactly that edge. imem_ack seen
// while imem_req is low is ignored.
//
// RESET_PC must be word-aligned.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_next_c,
  input  logic [31:0] reg_a,
  input  logic        retire,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic [5:0]  op_c,
  output logic [5:0]  funct,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] next_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        jr_misaligned;
  logic        fetch_ok;
  logic        retire_ok;

  // ---------------------------------------------------------------------
  // Combinational decode and next-PC selection
  // ---------------------------------------------------------------------
  assign pc_plus4  = pc + 32'd4;
  assign op_c      = instr[31:26];
  assign funct     = instr[5:0];
  assign imem_addr = pc;

  assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // A misaligned jr target is a fault rather than a redirect.
  assign jr_misaligned = pc_next_c[2] && (reg_a[1:0] != 2'b00);

  // Priority jr > j > branch > sequential; multi-bit selects are legal.
  always_comb begin
    next_pc = pc_plus4;
    if (pc_next_c[2])      next_pc = reg_a;
    else if (pc_next_c[1]) next_pc = jump_target;
    else if (pc_next_c[0]) next_pc = branch_target;
  end

  assign fetch_ok  = (state == FETCH) && imem_ack && !imem_err;
  assign retire_ok = (state == EXEC) && retire && !jr_misaligned;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (imem_ack) state_next = imem_err ? FAULT : EXEC;
      end
      EXEC: begin
        if (retire) state_next = jr_misaligned ? FAULT : FETCH;
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (fault is sticky because only reset leaves FAULT)
  // ---------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      FETCH:   imem_req    = 1'b1;
      EXEC:    instr_valid = 1'b1;
      FAULT:   fault       = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0000_0000;
    end else begin
      if (fetch_ok)  instr <= imem_rdata;
      if (retire_ok) pc    <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit.
//
// Walks boot, sequential/wrap, branch, jump, priority, jr fault, memory
// error fault and reset-mid-fetch with hand-computed expected values.

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pc_next_c;
  logic [31:0] reg_a;
  logic        retire;
  logic        imem_ack;
  logic        imem_err;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [5:0]  op_c;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next_c   (pc_next_c),
    .reg_a       (reg_a),
    .retire      (retire),
    .imem_ack    (imem_ack),
    .imem_err    (imem_err),
    .imem_rdata  (imem_rdata),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .op_c        (op_c),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  // ---------------------------------------------------------------------
  // Check and driver tasks
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bounded wait for imem_req, sampled on the falling edge, then check the
  // request address.
  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  // Ack the pending request at the next rising edge (zero wait).
  task automatic ack(input logic [31:0] data, input logic err);
    imem_ack   = 1'b1;
    imem_err   = err;
    imem_rdata = data;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_retire(input logic [2:0] sel, input logic [31:0] ra);
    retire    = 1'b1;
    pc_next_c = sel;
    reg_a     = ra;
    @(posedge clk);
    #1;
    retire    = 1'b0;
    pc_next_c = 3'b000;
    reg_a     = 32'h0;
    @(negedge clk);
  endtask

  // Assert reset, check reset values, release with a stray ack present in
  // the first cycle after release, then expect a request at RST_PC.
  task automatic reset_release(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_req"},   {31'd0, imem_req},    32'd0);
    check({tag, "_rst_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_rst_fault"}, {31'd0, fault},       32'd0);
    check({tag, "_rst_pc"},    pc,                   RST_PC);
    check({tag, "_rst_instr"}, instr,                32'h0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_ack   = 1'b0;
    @(negedge clk);
    check({tag, "_rel_req"},   {31'd0, imem_req}, 32'd1);
    check({tag, "_rel_addr"},  imem_addr,         RST_PC);
    check({tag, "_rel_instr"}, instr,             32'h0);
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst_n      = 1'b0;
    pc_next_c  = 3'b000;
    reg_a      = 32'h0;
    retire     = 1'b0;
    imem_ack   = 1'b0;
    imem_err   = 1'b0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset_release("boot");

    // Boot: ack two cycles after request, address held stable.
    repeat (2) @(negedge clk);
    check("boot_hold_req",  {31'd0, imem_req}, 32'd1);
    check("boot_hold_addr", imem_addr, RST_PC);
    ack(32'h8C08_0004, 1'b0);
    check("boot_valid", {31'd0, instr_valid}, 32'd1);
    check("boot_op",    {26'd0, op_c},  32'h23);
    check("boot_funct", {26'd0, funct}, 32'h04);
    check("boot_req0",  {31'd0, imem_req}, 32'd0);
    check("boot_plus4", pc_plus4, 32'h0040_0004);

    // Ack outside FETCH is ignored.
    ack(32'h1111_1111, 1'b0);
    check("exec_ack_ign", instr, 32'h8C08_0004);

    // Sequential.
    do_retire(3'b000, 32'h0);
    check("seq_valid0", {31'd0, instr_valid}, 32'd0);
    wait_req("seq", 32'h0040_0004);

    // jr to the top word, then sequential wrap to zero.
    ack(32'h0000_0000, 1'b0);
    do_retire(3'b100, 32'hFFFF_FFFC);
    wait_req("jr_top", 32'hFFFF_FFFC);
    ack(32'h0000_0000, 1'b0);
    check("wrap_plus4", pc_plus4, 32'h0000_0000);
    do_retire(3'b000, 32'h0);
    wait_req("wrap", 32'h0000_0000);

    // Branch with offset -1 word back to itself.
    ack(32'h0000_0000, 1'b0);
    do_retire(3'b100, 32'h0000_0100);
    wait_req("jr_100", 32'h0000_0100);
    ack(32'h1000_FFFF, 1'b0);
    do_retire(3'b001, 32'h0);
    wait_req("branch", 32'h0000_0100);

    // Jump keeps pc_plus4[31:28].
    ack(32'h0000_0000, 1'b0);
    do_retire(3'b100, 32'h3000_0000);
    wait_req("jr_3000", 32'h3000_0000);
    ack(32'h0800_0040, 1'b0);
    do_retire(3'b010, 32'h0);
    wait_req("jump", 32'h3000_0100);

    // Priority: 111 takes jr, 011 takes j over branch.
    ack(32'h0800_0040, 1'b0);
    do_retire(3'b111, 32'h0000_0200);
    wait_req("prio_jr", 32'h0000_0200);
    ack(32'h0800_0040, 1'b0);
    do_retire(3'b011, 32'h0);
    wait_req("prio_j", 32'h0000_0100);

    // Misaligned jr: fault, no request, pc held, instr_valid cleared.
    ack(32'h1234_5678, 1'b0);
    do_retire(3'b100, 32'h0000_0202);
    check("jrf_fault", {31'd0, fault},       32'd1);
    check("jrf_req",   {31'd0, imem_req},    32'd0);
    check("jrf_valid", {31'd0, instr_valid}, 32'd0);
    check("jrf_pc",    pc, 32'h0000_0100);
    ack(32'hFFFF_FFFF, 1'b0);
    do_retire(3'b000, 32'h0);
    repeat (3) @(negedge clk);
    check("jrf_sticky", {31'd0, fault},    32'd1);
    check("jrf_req2",   {31'd0, imem_req}, 32'd0);
    check("jrf_instr",  instr, 32'h1234_5678);

    // Memory error: fault, instr unchanged.
    reset_release("err");
    ack(32'hAAAA_5555, 1'b0);
    do_retire(3'b000, 32'h0);
    wait_req("err_seq", 32'h0040_0004);
    ack(32'hFFFF_FFFF, 1'b1);
    check("err_fault", {31'd0, fault},       32'd1);
    check("err_instr", instr, 32'hAAAA_5555);
    check("err_valid", {31'd0, instr_valid}, 32'd0);
    check("err_req",   {31'd0, imem_req},    32'd0);
    repeat (3) @(negedge clk);
    check("err_sticky", {31'd0, fault}, 32'd1);

    // Reset while a fetch is pending.
    reset_release("mid0");
    ack(32'h0000_0000, 1'b0);
    do_retire(3'b000, 32'h0);
    wait_req("mid_pre", 32'h0040_0004);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    reset_release("mid");
    ack(32'hCAFE_0001, 1'b0);
    check("mid_instr", instr, 32'hCAFE_0001);
    check("mid_valid", {31'd0, instr_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch and next-PC block that feeds the main control decoder and consumes its PC-select output. It holds the PC, fetches each instruction from instruction memory over a req/ack handshake, and presents the instruction fields (op_c, funct, raw word) with a valid flag. On retire it applies the decoder's 3-bit pc_next_c select {jr, j, branch} to form the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_next_c  in  3  {jr, j, branch} select from the control decoder; sampled only on retire.
- reg_a  in  32  rs register value, the jr target; sampled only on retire.
- retire  in  1  the core has finished executing the held instruction this cycle.
- imem_ack  in  1  memory has returned data for the current request.
- imem_err  in  1  memory access failed; qualified by imem_ack.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  32  fetch address, equal to pc.
- instr  out  32  latched instruction word.
- op_c  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_valid  out  1  instr, op_c and funct are valid for execution.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4, modulo 2^32.
- fault  out  1  sticky fetch or alignment fault.

## Operation
- States: IDLE, FETCH, EXEC, FAULT.
- Reset values:
  - pc=RESET_PC; instr=0; instr_valid=0; imem_req=0; fault=0.
  - State is IDLE.
- IDLE: always moves to FETCH on the next edge. Ack, err and retire are ignored.
- FETCH: imem_req=1, imem_addr=pc, both stable until ack.
  - imem_ack=1, imem_err=0: latch imem_rdata into instr, set instr_valid=1, move to EXEC.
  - imem_ack=1, imem_err=1: set fault=1, move to FAULT. instr is unchanged.
- EXEC: imem_req=0, instr_valid=1. On retire, load pc with next_pc, clear instr_valid, move to FETCH.
- next_pc is selected by priority jr > j > branch > sequential:
  - jr: reg_a.
  - j: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - branch: pc_plus4 + (sign-extend(instr[15:0]) << 2), modulo 2^32.
  - none set (000): pc_plus4.
- If pc_next_c has more than one bit set, priority resolves it; no error is raised.
- jr with reg_a[1:0] != 0: set fault=1, move to FAULT, leave pc unchanged, clear instr_valid.
- FAULT: imem_req=0, instr_valid=0, fault=1. Only reset leaves this state.
- retire outside EXEC is ignored. imem_ack outside FETCH is ignored.
- All address arithmetic is 32-bit and wraps: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Reset mid-operation: all outputs return to their reset values immediately, asynchronously. An ack arriving in the first cycle after reset release is ignored because the block is in IDLE.

## Timing
- Reset release at edge R: imem_req rises after edge R+1.
- Ack sampled at edge N: instr_valid=1 and instr updated after edge N; imem_req=0 after edge N.
- Zero-wait memory (ack in the first req cycle) gives 2 cycles per instruction minimum: one FETCH cycle, one EXEC cycle.
- Retire sampled at edge M: pc/imem_addr hold the new address and imem_req=1 after edge M; instr_valid=0 after edge M.
- op_c, funct and pc_plus4 are combinational from the instr and pc registers.
- pc_next_c and reg_a need to be valid only at the retire edge.

## Test plan
- Boot: RESET_PC=0x0040_0000; ack 2 cycles after req with rdata=0x8C08_0004.
  - imem_addr=0x0040_0000 while requesting.
  - After ack: instr_valid=1, op_c=0x23, funct=0x04.
- Sequential and wrap:
  - Retire with pc_next_c=000 at pc 0x0040_0000: next imem_addr=0x0040_0004.
  - Same at pc 0xFFFF_FFFC: next imem_addr=0x0000_0000.
- Branch: pc=0x100, instr=0x1000_FFFF, retire with pc_next_c=001.
  - Next imem_addr=0x100 (pc+4 plus offset -4).
- Jump and priority:
  - pc=0x3000_0000, instr=0x0800_0040, pc_next_c=010: next imem_addr=0x3000_0100.
  - pc_next_c=111 with reg_a=0x200: next imem_addr=0x200.
- Faults:
  - jr with reg_a=0x202: fault=1, imem_req stays 0, pc unchanged.
  - Separately, ack with err=1 during FETCH: fault=1, instr unchanged.
  - In both cases only rst_n clears fault.
- Reset mid-fetch: rst_n low while imem_req=1 and ack pending.
  - Outputs go to reset values within the reset cycle.
  - An ack in the first cycle after release is ignored.
  - imem_req rises one edge after release with imem_addr=RESET_PC.
